// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops until both operands are ready,
// snoops the writeback bus for wakeup and issues one ready entry per cycle.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif

module alu_rs #(
    parameter int ENTRY_NUM = 4,
    parameter int ENTRY_SEL = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     kill_i,
    input  logic                     dispatch_i,
    output logic                     dispatch_ready_o,
    input  logic [`ALU_OP_WIDTH-1:0] alu_op_i,
    input  logic [`DATA_LEN-1:0]     src1_i,
    input  logic                     src1_valid_i,
    input  logic [`RRF_SEL-1:0]      src1_tag_i,
    input  logic [`DATA_LEN-1:0]     src2_i,
    input  logic                     src2_valid_i,
    input  logic [`RRF_SEL-1:0]      src2_tag_i,
    input  logic [`RRF_SEL-1:0]      rrf_tag_i,
    input  logic                     if_write_rrf_i,
    input  logic [`DATA_LEN-1:0]     wb_result_i,
    input  logic [`RRF_SEL-1:0]      wb_tag_i,
    input  logic                     wb_we_i,
    output logic                     issue_o,
    output logic [`ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [`DATA_LEN-1:0]     src1_o,
    output logic [`DATA_LEN-1:0]     src2_o,
    output logic [`RRF_SEL-1:0]      rrf_tag_o,
    output logic                     if_write_rrf_o,
    output logic [ENTRY_SEL:0]       count_o
);

    typedef struct packed {
        logic [`DATA_LEN-1:0] value;
        logic                 ready;
        logic [`RRF_SEL-1:0]  tag;
    } src_t;

    typedef struct packed {
        logic [`ALU_OP_WIDTH-1:0] op;
        logic [`RRF_SEL-1:0]      rrf_tag;
        logic                     if_write_rrf;
        src_t                     s1;
        src_t                     s2;
    } entry_t;

    logic [ENTRY_NUM-1:0] valid_q;
    entry_t               ent_q [ENTRY_NUM];
    logic [ENTRY_SEL:0]   count_q;

    logic                 free_found, sel_found, accept;
    logic [ENTRY_SEL-1:0] free_idx, sel_idx;
    entry_t               new_entry;

    // A source missing at dispatch can still be filled by a same-cycle broadcast.
    function automatic src_t capture(input logic [`DATA_LEN-1:0] value,
                                     input logic valid, input logic [`RRF_SEL-1:0] tag);
        src_t s;
        s.tag   = tag;
        s.value = value;
        s.ready = valid;
        if (!valid && wb_we_i && (wb_tag_i == tag)) begin
            s.value = wb_result_i;
            s.ready = 1'b1;
        end
        return s;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = ENTRY_SEL'(i);
            end
            if (!sel_found && valid_q[i] && ent_q[i].s1.ready && ent_q[i].s2.ready) begin
                sel_found = 1'b1;
                sel_idx   = ENTRY_SEL'(i);
            end
        end
    end

    assign dispatch_ready_o = (count_q != (ENTRY_SEL+1)'(ENTRY_NUM));
    assign accept           = dispatch_i && dispatch_ready_o && free_found;
    assign count_o          = count_q;

    always_comb begin
        new_entry.op           = alu_op_i;
        new_entry.rrf_tag      = rrf_tag_i;
        new_entry.if_write_rrf = if_write_rrf_i;
        new_entry.s1           = capture(src1_i, src1_valid_i, src1_tag_i);
        new_entry.s2           = capture(src2_i, src2_valid_i, src2_tag_i);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            valid_q        <= '0;
            count_q        <= '0;
            issue_o        <= 1'b0;
            alu_op_o       <= '0;
            src1_o         <= '0;
            src2_o         <= '0;
            rrf_tag_o      <= '0;
            if_write_rrf_o <= 1'b0;
        end else if (kill_i) begin
            valid_q <= '0;
            count_q <= '0;
            issue_o <= 1'b0;
        end else begin
            issue_o <= sel_found;
            if (sel_found) begin
                alu_op_o          <= ent_q[sel_idx].op;
                src1_o            <= ent_q[sel_idx].s1.value;
                src2_o            <= ent_q[sel_idx].s2.value;
                rrf_tag_o         <= ent_q[sel_idx].rrf_tag;
                if_write_rrf_o    <= ent_q[sel_idx].if_write_rrf;
                valid_q[sel_idx]  <= 1'b0;
            end
            if (accept) valid_q[free_idx] <= 1'b1;
            count_q <= count_q + (ENTRY_SEL+1)'(accept) - (ENTRY_SEL+1)'(sel_found);
        end
    end

    // NOTE: entry payload is not reset; valid_q alone decides whether an entry is live.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (valid_q[i] && wb_we_i) begin
                if (!ent_q[i].s1.ready && ent_q[i].s1.tag == wb_tag_i) begin
                    ent_q[i].s1.value <= wb_result_i;
                    ent_q[i].s1.ready <= 1'b1;
                end
                if (!ent_q[i].s2.ready && ent_q[i].s2.tag == wb_tag_i) begin
                    ent_q[i].s2.value <= wb_result_i;
                    ent_q[i].s2.ready <= 1'b1;
                end
            end
        end
        if (accept) ent_q[free_idx] <= new_entry;
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: reset, issue latency, wakeup,
// dispatch bypass, full/priority behaviour and flush.
module tb_alu_rs;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        dispatch_i = 1'b0;
    logic        dispatch_ready_o;
    logic [3:0]  alu_op_i = '0;
    logic [31:0] src1_i = '0;
    logic        src1_valid_i = 1'b0;
    logic [5:0]  src1_tag_i = '0;
    logic [31:0] src2_i = '0;
    logic        src2_valid_i = 1'b0;
    logic [5:0]  src2_tag_i = '0;
    logic [5:0]  rrf_tag_i = '0;
    logic        if_write_rrf_i = 1'b0;
    logic [31:0] wb_result_i = '0;
    logic [5:0]  wb_tag_i = '0;
    logic        wb_we_i = 1'b0;
    logic        issue_o;
    logic [3:0]  alu_op_o;
    logic [31:0] src1_o;
    logic [31:0] src2_o;
    logic [5:0]  rrf_tag_o;
    logic        if_write_rrf_o;
    logic [2:0]  count_o;

    int n_cmp = 0;
    int n_mis = 0;

    alu_rs #(.ENTRY_NUM(4), .ENTRY_SEL(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .kill_i(kill_i),
        .dispatch_i(dispatch_i), .dispatch_ready_o(dispatch_ready_o),
        .alu_op_i(alu_op_i),
        .src1_i(src1_i), .src1_valid_i(src1_valid_i), .src1_tag_i(src1_tag_i),
        .src2_i(src2_i), .src2_valid_i(src2_valid_i), .src2_tag_i(src2_tag_i),
        .rrf_tag_i(rrf_tag_i), .if_write_rrf_i(if_write_rrf_i),
        .wb_result_i(wb_result_i), .wb_tag_i(wb_tag_i), .wb_we_i(wb_we_i),
        .issue_o(issue_o), .alu_op_o(alu_op_o), .src1_o(src1_o), .src2_o(src2_o),
        .rrf_tag_o(rrf_tag_o), .if_write_rrf_o(if_write_rrf_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] s1, input logic v1,
                        input logic [5:0] t1, input logic [31:0] s2, input logic v2,
                        input logic [5:0] t2, input logic [5:0] rrf, input logic wr);
        dispatch_i     = 1'b1;
        alu_op_i       = op;
        src1_i         = s1;
        src1_valid_i   = v1;
        src1_tag_i     = t1;
        src2_i         = s2;
        src2_valid_i   = v2;
        src2_tag_i     = t2;
        rrf_tag_i      = rrf;
        if_write_rrf_i = wr;
    endtask

    task automatic bcast(input logic [5:0] tag, input logic [31:0] val);
        wb_we_i     = 1'b1;
        wb_tag_i    = tag;
        wb_result_i = val;
    endtask

    initial begin
        // Reset held two cycles while dispatch is asserted.
        disp(4'd1, 32'd1, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd7, 1'b1);
        tick();
        tick();
        reset_i    = 1'b1;
        dispatch_i = 1'b0;
        check("rst_count", count_o, 0);
        check("rst_issue", issue_o, 0);
        check("rst_ready", dispatch_ready_o, 1);
        check("rst_rrf_tag", rrf_tag_o, 0);
        check("rst_src1", src1_o, 0);
        tick();
        check("rst_no_issue_after", issue_o, 0);

        // Ready dispatch: ADD 5,7 -> tag 3, issues two cycles later.
        disp(4'd1, 32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd3, 1'b1);
        tick();
        dispatch_i = 1'b0;
        check("rd_count1", count_o, 1);
        check("rd_issue_c1", issue_o, 0);
        tick();
        check("rd_issue_c2", issue_o, 1);
        check("rd_op", alu_op_o, 4'd1);
        check("rd_src1", src1_o, 32'd5);
        check("rd_src2", src2_o, 32'd7);
        check("rd_rrf", rrf_tag_o, 6'd3);
        check("rd_wr", if_write_rrf_o, 1);
        check("rd_count0", count_o, 0);
        tick();
        check("rd_issue_drop", issue_o, 0);
        check("rd_src1_hold", src1_o, 32'd5);

        // Wakeup: src2 waits on tag 9; a tag-8 broadcast must not wake it.
        disp(4'd2, 32'd10, 1'b1, 6'd0, 32'd0, 1'b0, 6'd9, 6'd5, 1'b0);
        tick();
        dispatch_i = 1'b0;
        bcast(6'd8, 32'h55);
        tick();
        wb_we_i = 1'b0;
        check("wk_no_issue_c2", issue_o, 0);
        tick();
        check("wk_no_issue_c3", issue_o, 0);
        bcast(6'd9, 32'h20);
        tick();
        wb_we_i = 1'b0;
        check("wk_no_issue_c4", issue_o, 0);
        tick();
        check("wk_issue_c5", issue_o, 1);
        check("wk_src1", src1_o, 32'd10);
        check("wk_src2", src2_o, 32'h20);
        check("wk_op", alu_op_o, 4'd2);
        check("wk_wr", if_write_rrf_o, 0);
        check("wk_rrf", rrf_tag_o, 6'd5);
        tick();
        check("wk_count0", count_o, 0);

        // Same-cycle bypass of a dispatching source.
        disp(4'd3, 32'd3, 1'b1, 6'd0, 32'd0, 1'b0, 6'd4, 6'd6, 1'b1);
        bcast(6'd4, 32'hAB);
        tick();
        dispatch_i = 1'b0;
        wb_we_i    = 1'b0;
        check("bp_issue_c1", issue_o, 0);
        tick();
        check("bp_issue_c2", issue_o, 1);
        check("bp_src2", src2_o, 32'hAB);
        check("bp_src1", src1_o, 32'd3);
        tick();

        // Fill four entries all waiting on tag 1.
        for (int i = 0; i < 4; i++) begin
            disp(4'd4, 32'd0, 1'b0, 6'd1, 32'd100 + i, 1'b1, 6'd0, 6'd10 + 6'(i), 1'b1);
            tick();
        end
        check("full_count", count_o, 4);
        check("full_ready", dispatch_ready_o, 0);
        // Fifth dispatch is fully ready; it would issue if wrongly accepted.
        disp(4'd5, 32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd20, 1'b1);
        tick();
        dispatch_i = 1'b0;
        check("full_ignored_count", count_o, 4);
        tick();
        check("full_ignored_issue", issue_o, 0);
        bcast(6'd1, 32'h11);
        tick();
        wb_we_i = 1'b0;
        check("full_wake_no_issue_yet", issue_o, 0);
        check("full_ready_before_issue", dispatch_ready_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("prio_issue", issue_o, 1);
            check("prio_rrf", rrf_tag_o, 6'd10 + 6'(i));
            check("prio_src2", src2_o, 32'd100 + i);
            check("prio_src1", src1_o, 32'h11);
            check("prio_count", count_o, 3 - i);
            check("prio_ready", dispatch_ready_o, 1);
        end
        tick();
        check("prio_done", issue_o, 0);

        // Flush with three entries pending while an issue is in flight.
        for (int i = 0; i < 4; i++) begin
            disp(4'd6, 32'd0, 1'b0, 6'd2, 32'd0, 1'b1, 6'd0, 6'd30 + 6'(i), 1'b0);
            tick();
        end
        dispatch_i = 1'b0;
        bcast(6'd2, 32'h22);
        tick();
        wb_we_i = 1'b0;
        tick();
        check("fl_pre_issue", issue_o, 1);
        check("fl_pre_count", count_o, 3);
        kill_i = 1'b1;
        disp(4'd7, 32'd9, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 6'd40, 1'b1);
        tick();
        kill_i     = 1'b0;
        dispatch_i = 1'b0;
        check("fl_count", count_o, 0);
        check("fl_issue", issue_o, 0);
        check("fl_ready", dispatch_ready_o, 1);
        bcast(6'd2, 32'h33);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_we_i = 1'b0;
            check("fl_no_later_issue", issue_o, 0);
            check("fl_count_stays", count_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
